// File: rtl/logo_bouncer.sv
// logo_bouncer -- draws one rectangular logo that moves autonomously across
// the visible area and bounces off the screen edges.
//
// Position/direction update once per frame on a registered tick taken at the
// start of vertical blank (x_px == 0, y_px == V_ACTIVE). Two raw push buttons
// are synchronised and debounced; their debounced rising edges step a
// saturating speed register. Each bounce emits a sound code that is held for
// SOUND_FRAMES frame ticks.
//
// Optional feature macro: BOUNCE_COLOR_EN
//   defined   -> logo colour advances 001..111 (skipping 000) on every tick
//                with any bounce (a corner advances once)
//   undefined -> logo colour is the constant LOGO_COLOR
//
// Ports:
//   clk        in   pixel clock (px_clk from vga_controller)
//   clr        in   asynchronous active-high reset
//   x_px       in   current pixel column [9:0]
//   y_px       in   current pixel line   [9:0]
//   inc_vel    in   raw button, increase speed
//   dec_vel    in   raw button, decrease speed
//   color_px   out  registered RGB for the current pixel [2:0]
//   code_sound out  00 none, 01 X bounce, 10 Y bounce, 11 corner
//   mute       out  high when code_sound == 00
module logo_bouncer #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned LOGO_W       = 64,
    parameter int unsigned LOGO_H       = 32,
    parameter int unsigned VEL_W        = 3,
    parameter int unsigned VEL_INIT     = 1,
    parameter int unsigned DEB_CYCLES   = 65536,
    parameter int unsigned SOUND_FRAMES = 4,
    parameter logic [2:0]  LOGO_COLOR   = 3'b111
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] x_px,
    input  logic [9:0] y_px,
    input  logic       inc_vel,
    input  logic       dec_vel,
    output logic [2:0] color_px,
    output logic [1:0] code_sound,
    output logic       mute
);

    localparam int unsigned XMAX = H_ACTIVE - LOGO_W;
    localparam int unsigned YMAX = V_ACTIVE - LOGO_H;
    localparam int unsigned DCW  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned SCW  = $clog2(SOUND_FRAMES + 1);
    localparam logic [VEL_W-1:0] VEL_MAX = '1;
    localparam logic [VEL_W-1:0] VEL_MIN = VEL_W'(1);

    typedef struct packed {
        logic       dir;   // 1 = moving towards MAX
        logic [9:0] pos;
    } axis_t;

    typedef struct packed {
        logic  bounce;
        axis_t ax;
    } step_t;

    // One frame of motion on one axis; 11-bit arithmetic so pos+speed cannot
    // wrap and pos-speed never underflows into a large position.
    function automatic step_t step_axis(input axis_t cur, input logic [10:0] spd,
                                        input logic [10:0] lim);
        step_t      nxt;
        logic [10:0] wide;
        nxt.ax     = cur;
        nxt.bounce = 1'b0;
        if (cur.dir) begin
            wide = {1'b0, cur.pos} + spd;
            if (wide >= lim) begin
                nxt.ax.pos = lim[9:0];
                nxt.ax.dir = 1'b0;
                nxt.bounce = 1'b1;
            end else begin
                nxt.ax.pos = wide[9:0];
            end
        end else begin
            wide = {1'b0, cur.pos} - spd;
            if ({1'b0, cur.pos} <= spd) begin
                nxt.ax.pos = '0;
                nxt.ax.dir = 1'b1;
                nxt.bounce = 1'b1;
            end else begin
                nxt.ax.pos = wide[9:0];
            end
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Button synchronisers and debouncers, bit 0 = inc, bit 1 = dec
    // ------------------------------------------------------------------
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     deb_q, deb_d;
    logic [DCW-1:0] deb_cnt_q [2];
    logic [DCW-1:0] deb_cnt_d [2];
    logic [1:0]     rise;

    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                // DEB_CYCLES consecutive differing samples: accept new level
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
                rise[i]      = sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q   <= {dec_vel, inc_vel};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Speed register (saturating 1 .. 2^VEL_W-1)
    // ------------------------------------------------------------------
    logic [VEL_W-1:0] speed_q, speed_d;

    always_comb begin
        speed_d = speed_q;
        if (rise[0] && !rise[1] && speed_q != VEL_MAX) begin
            speed_d = speed_q + VEL_W'(1);
        end else if (rise[1] && !rise[0] && speed_q != VEL_MIN) begin
            speed_d = speed_q - VEL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame tick and motion
    // ------------------------------------------------------------------
    logic  tick_q;
    axis_t ax_q, ax_d, ay_q, ay_d;
    step_t sx, sy;
    logic  bounce_x, bounce_y, bounce_any;

    always_comb begin
        sx         = step_axis(ax_q, 11'(speed_q), 11'(XMAX));
        sy         = step_axis(ay_q, 11'(speed_q), 11'(YMAX));
        ax_d       = ax_q;
        ay_d       = ay_q;
        bounce_x   = 1'b0;
        bounce_y   = 1'b0;
        if (tick_q) begin
            ax_d     = sx.ax;
            ay_d     = sy.ax;
            bounce_x = sx.bounce;
            bounce_y = sy.bounce;
        end
        bounce_any = bounce_x | bounce_y;
    end

    // ------------------------------------------------------------------
    // Sound code, held for SOUND_FRAMES ticks after the latest bounce
    // ------------------------------------------------------------------
    logic [1:0]     code_q, code_d;
    logic [SCW-1:0] snd_cnt_q, snd_cnt_d;
    logic           mute_q;

    always_comb begin
        code_d    = code_q;
        snd_cnt_d = snd_cnt_q;
        if (bounce_any) begin
            code_d    = {bounce_y, bounce_x};
            snd_cnt_d = SCW'(SOUND_FRAMES);
        end else if (tick_q && snd_cnt_q != '0) begin
            snd_cnt_d = snd_cnt_q - SCW'(1);
            if (snd_cnt_q == SCW'(1)) begin
                code_d = 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Logo colour
    // ------------------------------------------------------------------
    logic [2:0] colour;
`ifdef BOUNCE_COLOR_EN
    logic [2:0] colour_q, colour_d;

    always_comb begin
        colour_d = colour_q;
        if (bounce_any) begin
            colour_d = (colour_q == 3'b111) ? 3'b001 : colour_q + 3'd1;
        end
        colour = colour_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            colour_q <= LOGO_COLOR;
        end else begin
            colour_q <= colour_d;
        end
    end
`else
    always_comb begin
        colour = LOGO_COLOR;
    end
`endif

    // ------------------------------------------------------------------
    // Pixel output
    // ------------------------------------------------------------------
    logic [2:0]  color_q, color_d;
    logic        in_x, in_y;
    logic [10:0] px_x, px_y;

    always_comb begin
        px_x    = {1'b0, x_px};
        px_y    = {1'b0, y_px};
        in_x    = (px_x < 11'(H_ACTIVE)) && (px_x >= {1'b0, ax_q.pos})
                  && (px_x < {1'b0, ax_q.pos} + 11'(LOGO_W));
        in_y    = (px_y < 11'(V_ACTIVE)) && (px_y >= {1'b0, ay_q.pos})
                  && (px_y < {1'b0, ay_q.pos} + 11'(LOGO_H));
        color_d = (in_x && in_y) ? colour : '0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tick_q    <= 1'b0;
            ax_q      <= '{dir: 1'b1, pos: 10'((H_ACTIVE - LOGO_W) / 2)};
            ay_q      <= '{dir: 1'b1, pos: 10'((V_ACTIVE - LOGO_H) / 2)};
            speed_q   <= VEL_W'(VEL_INIT);
            code_q    <= 2'b00;
            snd_cnt_q <= '0;
            mute_q    <= 1'b1;
            color_q   <= '0;
        end else begin
            tick_q    <= (x_px == '0) && (y_px == 10'(V_ACTIVE));
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            speed_q   <= speed_d;
            code_q    <= code_d;
            snd_cnt_q <= snd_cnt_d;
            mute_q    <= (code_d == 2'b00);
            color_q   <= color_d;
        end
    end

    assign color_px   = color_q;
    assign code_sound = code_q;
    assign mute       = mute_q;

endmodule

// File: tb/tb_logo_bouncer.sv
module tb_logo_bouncer;

    logic       clk = 1'b0;
    logic       clr;
    logic [9:0] x_px, y_px;
    logic       inc_vel, dec_vel;
    logic [2:0] color_px;
    logic [1:0] code_sound;
    logic       mute;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] exp;
        string      name;
    } probe_t;

    logo_bouncer #(
        .H_ACTIVE    (64),
        .V_ACTIVE    (48),
        .LOGO_W      (8),
        .LOGO_H      (4),
        .VEL_W       (3),
        .VEL_INIT    (1),
        .DEB_CYCLES  (4),
        .SOUND_FRAMES(2),
        .LOGO_COLOR  (3'b111)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .x_px      (x_px),
        .y_px      (y_px),
        .inc_vel   (inc_vel),
        .dec_vel   (dec_vel),
        .color_px  (color_px),
        .code_sound(code_sound),
        .mute      (mute)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // Expected logo colour after n bounce ticks since reset.
    function automatic logic [2:0] col_after(input int unsigned n);
`ifdef BOUNCE_COLOR_EN
        return 3'(((6 + n) % 7) + 1);
`else
        return 3'(n * 0 + 7);
`endif
    endfunction

    function automatic probe_t mk(input int unsigned x, input int unsigned y,
                                  input logic [2:0] e, input string nm);
        probe_t p;
        p.x = 10'(x); p.y = 10'(y); p.exp = e; p.name = nm;
        return p;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_px();
        x_px = 10'd1023;
        y_px = 10'd1023;
    endtask

    task automatic probe(input int unsigned x, input int unsigned y,
                         input logic [2:0] e, input string nm);
        x_px = 10'(x);
        y_px = 10'(y);
        @(posedge clk); #1;
        check(nm, {1'b0, color_px}, {1'b0, e});
        idle_px();
    endtask

    task automatic do_tick();
        x_px = 10'd0;
        y_px = 10'd48;
        @(posedge clk); #1;
        idle_px();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) do_tick();
    endtask

    task automatic check_snd(input string nm, input logic [1:0] c);
        check({nm, " code"}, {2'b0, code_sound}, {2'b0, c});
        check({nm, " mute"}, {3'b0, mute}, {3'b0, c == 2'b00});
    endtask

    task automatic press(input logic inc, input logic dec, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            inc_vel = inc;
            dec_vel = dec;
            repeat (8) @(posedge clk);
            #1;
            inc_vel = 1'b0;
            dec_vel = 1'b0;
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    probe_t tab [8];

    initial begin
        clr     = 1'b1;
        inc_vel = 1'b0;
        dec_vel = 1'b0;
        idle_px();
        tab[0] = mk(28, 22, 3'b111, "t1 inside top-left");
        tab[1] = mk(35, 25, 3'b111, "t1 inside bottom-right");
        tab[2] = mk(36, 22, 3'b000, "t1 right of logo");
        tab[3] = mk(27, 22, 3'b000, "t1 left of logo");
        tab[4] = mk(28, 26, 3'b000, "t1 below logo");
        tab[5] = mk(28, 21, 3'b000, "t1 above logo");
        tab[6] = mk(1023, 22, 3'b000, "t1 x off-screen");
        tab[7] = mk(31, 48, 3'b000, "t1 y off-screen");

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset color", {1'b0, color_px}, 4'h0);
        check_snd("reset", 2'b00);
        clr = 1'b0;
        @(posedge clk); #1;

        // 1. Pixel window at reset position (28,22)
        foreach (tab[i]) probe(tab[i].x, tab[i].y, tab[i].exp, tab[i].name);

        // 2. Free run: Y bounce at tick 22, X bounce at tick 28
        ticks(21);
        check_snd("t2 tick21", 2'b00);
        do_tick();
        check_snd("t2 tick22", 2'b10);
        probe(50, 44, col_after(1), "t2 y at 44");
        probe(50, 43, 3'b000, "t2 above y 44");
        do_tick();
        check_snd("t2 tick23", 2'b10);
        do_tick();
        check_snd("t2 tick24", 2'b00);
        ticks(4);
        check_snd("t2 tick28", 2'b01);
        probe(56, 38, col_after(2), "t2 x at 56");
        probe(55, 38, 3'b000, "t2 left of 56");
        probe(63, 41, col_after(2), "t2 far corner");
        probe(56, 42, 3'b000, "t2 below logo");

        // 5. Heading - at x=5 (tick 79), speed 7: clamp to 0, no underflow
        ticks(51);
        check_snd("t5 tick79", 2'b00);
        probe(5, 13, col_after(3), "t5 x at 5");
        probe(4, 13, 3'b000, "t5 left of 5");
        press(1'b1, 1'b0, 10);
        do_tick();
        check_snd("t5 tick80", 2'b01);
        probe(0, 20, col_after(4), "t5 x at 0");
        probe(7, 20, col_after(4), "t5 x right edge");
        probe(8, 20, 3'b000, "t5 right of logo");
        probe(63, 20, 3'b000, "t5 no wrap");
        do_tick();
        probe(7, 27, col_after(4), "t5 moving +");
        probe(6, 27, 3'b000, "t5 left after +");

        // 4. Speed control
        do_reset();
        press(1'b1, 1'b0, 1);
        do_tick();
        probe(30, 24, 3'b111, "t4 speed2");
        probe(29, 24, 3'b000, "t4 speed2 left");
        do_reset();
        press(1'b1, 1'b0, 10);
        do_tick();
        probe(35, 29, 3'b111, "t4 sat7");
        probe(34, 29, 3'b000, "t4 sat7 left");
        press(1'b0, 1'b1, 10);
        do_tick();
        probe(36, 30, 3'b111, "t4 floor1");
        probe(35, 30, 3'b000, "t4 floor1 left");
        inc_vel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inc_vel = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_tick();
        probe(37, 31, 3'b111, "t4 glitch");
        probe(36, 31, 3'b000, "t4 glitch left");
        press(1'b1, 1'b1, 1);
        do_tick();
        probe(38, 32, 3'b111, "t4 both");
        probe(37, 32, 3'b000, "t4 both left");

        // 3. Corners: speed 7 from reset hits (56,44) on tick 4; then at
        //    speed 1 the motion is periodic with 1232 ticks, so 1231 ticks
        //    later the logo sits at (55,43) heading + and corners again.
        do_reset();
        press(1'b1, 1'b0, 10);
        ticks(3);
        check_snd("t3 pre corner", 2'b00);
        do_tick();
        check_snd("t3 corner1", 2'b11);
        probe(56, 44, col_after(1), "t3 corner1 pos");
        probe(55, 44, 3'b000, "t3 corner1 left");
        press(1'b0, 1'b1, 10);
        ticks(1231);
        probe(55, 43, col_after(48), "t3 at 55,43");
        probe(54, 43, 3'b000, "t3 left of 55");
        probe(55, 42, 3'b000, "t3 above 43");
        do_tick();
        check_snd("t3 corner2", 2'b11);
        probe(56, 44, col_after(49), "t3 corner2 pos");

        // 6. Reset in the middle of a Y-bounce sound at speed 5
        do_reset();
        press(1'b1, 1'b0, 4);
        ticks(5);
        check_snd("t6 bounce", 2'b10);
        x_px = 10'd53;
        y_px = 10'd44;
        @(posedge clk); #1;
        check("t6 color before clr", {1'b0, color_px}, {1'b0, col_after(1)});
        clr = 1'b1;
        #1;
        check("t6 clr color", {1'b0, color_px}, 4'h0);
        check_snd("t6 clr", 2'b00);
        idle_px();
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        probe(28, 22, 3'b111, "t6 pos reset");
        probe(27, 22, 3'b000, "t6 pos reset left");
        do_tick();
        check_snd("t6 no residual", 2'b00);
        probe(29, 23, 3'b111, "t6 speed1");
        probe(28, 23, 3'b000, "t6 speed1 left");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logo_bouncer.md
Name: logo_bouncer

Overview:
Parametrised successor to the fixed logo engine: draws one rectangular logo that moves autonomously and bounces off the screen edges.
- Sits between vga_controller (which supplies x_px/y_px on px_clk) and the top-level sound outputs.
- Generalised over screen size, logo size and velocity width.
- Adds debounced, saturating speed control, per-axis bounce detection, timed sound codes and colour cycling on bounce.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
LOGO_W, 64, logo width in pixels (< H_ACTIVE)
LOGO_H, 32, logo height in lines (< V_ACTIVE)
VEL_W, 3, speed register width; speed range 1 .. 2^VEL_W-1 pixels/frame
VEL_INIT, 1, speed after reset
DEB_CYCLES, 65536, clk cycles a synchronised button must stay stable to be accepted
SOUND_FRAMES, 4, frames a non-zero code_sound is held
LOGO_COLOR, 3'b111, reset/fixed logo colour (never 3'b000)

Ports:
clk  in  1  pixel clock (px_clk from vga_controller)
clr  in  1  reset
x_px  in  10  current pixel column
y_px  in  10  current pixel line
inc_vel  in  1  raw button, increase speed
dec_vel  in  1  raw button, decrease speed
color_px  out  3  RGB for current pixel, registered
code_sound  out  2  00 none, 01 X bounce, 10 Y bounce, 11 corner
mute  out  1  high when code_sound == 00

Interface: one clock; reset is asynchronous and active-high (clk, clr).

Behaviour:
Reset values (async on clr):
- logo_x = (H_ACTIVE-LOGO_W)/2, logo_y = (V_ACTIVE-LOGO_H)/2.
- dir_x = dir_y = +, speed = VEL_INIT, colour = LOGO_COLOR.
- color_px = 0, code_sound = 0, mute = 1, sound frame counter = 0, debouncers cleared.

Frame tick:
- One-cycle pulse, registered, when x_px == 0 && y_px == V_ACTIVE (start of vertical blank).
- All motion happens only on the tick.

Motion per axis, computed with an 11-bit intermediate; XMAX = H_ACTIVE-LOGO_W, YMAX = V_ACTIVE-LOGO_H:
- Dir +: if pos+speed >= MAX, then pos = MAX, dir flips, bounce flag set; else pos += speed.
- Dir -: if pos <= speed, then pos = 0, dir flips, bounce flag set; else pos -= speed.
- Both axes are evaluated on the same tick. Both flags set means corner.

Sound:
- On a tick with any bounce: code_sound = {bounce_y, bounce_x}, counter = SOUND_FRAMES.
- Each tick without a bounce decrements the counter; code_sound = 00 when it reaches 0.
- A new bounce reloads the code and counter.
- mute = (code_sound == 00), registered alongside code_sound.

Pixel output, latency 1 clk:
- color_px = colour if logo_x <= x_px < logo_x+LOGO_W and logo_y <= y_px < logo_y+LOGO_H, else 000.
- Any x_px >= H_ACTIVE or y_px >= V_ACTIVE yields 000.

Buttons, each independently:
- 2-FF synchroniser, then a stability counter.
- Debounced level updates after DEB_CYCLES consecutive equal samples.
- Debounced rising edge of inc: speed = min(speed+1, 2^VEL_W-1).
- Debounced rising edge of dec: speed = max(speed-1, 1).
- Both edges in the same cycle: no change.
- Speed changes take effect at the next tick.

Reset mid-operation: all state returns to reset values immediately; no residual sound.

Optional Feature:
BOUNCE_COLOR_EN
- Defined: each tick with any bounce advances colour 001→010→…→111→001, skipping 000. A corner bounce advances once.
- Undefined: colour stays LOGO_COLOR and the cycling logic is not synthesised.

Test Plan:
Bench parameters: H_ACTIVE=64, V_ACTIVE=48, LOGO_W=8, LOGO_H=4, DEB_CYCLES=4, SOUND_FRAMES=2, VEL_INIT=1, VEL_W=3. Reset position is (28,22).
1. Reset, drive x_px=28,y_px=22 → color_px=111 one clk later; x_px=36 → 000; x_px=27 → 000; y_px=26 → 000.
2. Free-run 22 frame ticks → logo_y=44, dir_y flips, code_sound=10, mute=0 for 2 ticks then 00/mute=1. Tick 28 → logo_x=56, code_sound=01.
3. Force corner: load (55,43) via ticks at speed 1 heading + → next tick code_sound=11. With BOUNCE_COLOR_EN, colour advances exactly one step.
4. Hold inc_vel high 6 clks (≥ DEB_CYCLES+2) → speed 2; ten presses → saturates at 7. Ten dec presses → floor 1. Glitch inc_vel for 2 clks → no change.
5. Speed 7 heading −, logo_x=5 → next tick logo_x=0, dir_x=+, code_sound=01 (no underflow).
6. Assert clr while code_sound=10 and speed=5 → same cycle: code_sound=00, mute=1, color_px=0, position (28,22), speed 1.
